// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// CPU and DMA issue level requests; each granted access completes with a one-cycle ack.
module mem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [4:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [4:0]  dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    output logic [15:0] rdata,
    output logic [4:0]  mem_addr,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [1:0] LAT_M1   = 2'(MEM_LAT - 1);
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DMA  = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        last_dma_q, last_dma_d;
    logic        wr_q, wr_d;
    logic [1:0]  owner_q, owner_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        mem_wr_q, mem_wr_d;
    logic [15:0] rdata_q, rdata_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        dma_ack_q, dma_ack_d;

    // DMA wins when it is the only requester, or on a tie when the CPU was served last.
    logic grant_dma;
    logic grant_wr;
    assign grant_dma = dma_req && (!cpu_req || !last_dma_q);
    assign grant_wr  = grant_dma ? dma_wr : cpu_wr;

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            last_dma_q <= 1'b1;
            wr_q       <= 1'b0;
            owner_q    <= OWN_NONE;
            addr_q     <= 5'd0;
            wdata_q    <= 16'd0;
            mem_wr_q   <= 1'b0;
            rdata_q    <= 16'd0;
            cpu_ack_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_dma_q <= last_dma_d;
            wr_q       <= wr_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_wr_q   <= mem_wr_d;
            rdata_q    <= rdata_d;
            cpu_ack_q  <= cpu_ack_d;
            dma_ack_q  <= dma_ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    state_d = ACCESS;
                    cnt_d   = grant_wr ? 2'd0 : LAT_M1;
                end
            end
            ACCESS: begin
                if (cnt_q == 2'd0) state_d = ACK;
                else               cnt_d   = cnt_q - 2'd1;
            end
            ACK: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        last_dma_d = last_dma_q;
        wr_d       = wr_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        mem_wr_d   = 1'b0;
        cpu_ack_d  = 1'b0;
        dma_ack_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    last_dma_d = grant_dma;
                    wr_d       = grant_wr;
                    owner_d    = grant_dma ? OWN_DMA : OWN_CPU;
                    addr_d     = grant_dma ? dma_addr : cpu_addr;
                    wdata_d    = grant_dma ? dma_wdata : cpu_wdata;
                    mem_wr_d   = grant_wr;
                end
            end
            ACCESS: begin
                if (cnt_q == 2'd0) begin
                    if (!wr_q) rdata_d = mem_rdata;
                    cpu_ack_d = (owner_q == OWN_CPU);
                    dma_ack_d = (owner_q == OWN_DMA);
                end
            end
            ACK: begin
                owner_d = OWN_NONE;
                addr_d  = 5'd0;
                wdata_d = 16'd0;
            end
            default: begin
                owner_d = OWN_NONE;
            end
        endcase
    end

    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign rdata     = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = wdata_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 uses a 1-cycle memory, instance 1 a 3-cycle memory.
// Stimulus queues expected acks; a negedge monitor pops and compares them.
module tb_mem_arbiter;

    logic        clk;
    logic        Rst;
    logic        cpu_req   [2];
    logic        cpu_wr    [2];
    logic [4:0]  cpu_addr  [2];
    logic [15:0] cpu_wdata [2];
    logic        cpu_ack   [2];
    logic        dma_req   [2];
    logic        dma_wr    [2];
    logic [4:0]  dma_addr  [2];
    logic [15:0] dma_wdata [2];
    logic        dma_ack   [2];
    logic [15:0] rdata     [2];
    logic [4:0]  mem_addr  [2];
    logic        mem_wr    [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata [2];
    logic [1:0]  owner     [2];

    typedef struct {
        logic        dma;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    mem_arbiter #(.MEM_LAT(1)) u0 (
        .clk(clk), .Rst(Rst),
        .cpu_req(cpu_req[0]), .cpu_wr(cpu_wr[0]), .cpu_addr(cpu_addr[0]),
        .cpu_wdata(cpu_wdata[0]), .cpu_ack(cpu_ack[0]),
        .dma_req(dma_req[0]), .dma_wr(dma_wr[0]), .dma_addr(dma_addr[0]),
        .dma_wdata(dma_wdata[0]), .dma_ack(dma_ack[0]),
        .rdata(rdata[0]), .mem_addr(mem_addr[0]), .mem_wr(mem_wr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .owner(owner[0])
    );

    mem_arbiter #(.MEM_LAT(3)) u1 (
        .clk(clk), .Rst(Rst),
        .cpu_req(cpu_req[1]), .cpu_wr(cpu_wr[1]), .cpu_addr(cpu_addr[1]),
        .cpu_wdata(cpu_wdata[1]), .cpu_ack(cpu_ack[1]),
        .dma_req(dma_req[1]), .dma_wr(dma_wr[1]), .dma_addr(dma_addr[1]),
        .dma_wdata(dma_wdata[1]), .dma_ack(dma_ack[1]),
        .rdata(rdata[1]), .mem_addr(mem_addr[1]), .mem_wr(mem_wr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .owner(owner[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: combinational read for latency 1, two read registers for latency 3.
    logic [15:0] mem [2][32];
    logic [15:0] rd1_s1, rd1_s2;
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (mem_wr[i]) mem[i][mem_addr[i]] <= mem_wdata[i];
        rd1_s1 <= mem[1][mem_addr[1]];
        rd1_s2 <= rd1_s1;
    end
    assign mem_rdata[0] = mem[0][mem_addr[0]];
    assign mem_rdata[1] = rd1_s2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        logic empty;
        for (int i = 0; i < 2; i++) begin
            if (cpu_ack[i] || dma_ack[i]) begin
                empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
                if (empty) begin
                    chk($sformatf("unexpected_ack_u%0d", i), {30'd0, dma_ack[i], cpu_ack[i]}, 0);
                end else begin
                    if (i == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("ack_who_u%0d", i), {30'd0, dma_ack[i], cpu_ack[i]}, e.dma ? 2 : 1);
                    chk($sformatf("ack_rdata_u%0d", i), rdata[i], e.rdata);
                    chk($sformatf("ack_cycle_u%0d", i), cyc, e.cyc);
                    chk($sformatf("ack_owner_u%0d", i), owner[i], e.dma ? 2 : 1);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic dma, input logic [15:0] rd, input int c);
        exp_t e;
        e.dma = dma;
        e.rdata = rd;
        e.cyc = c;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drive(input int i, input logic dma, input logic req, input logic wr,
                         input logic [4:0] addr, input logic [15:0] wd);
        if (dma) begin
            dma_req[i] = req; dma_wr[i] = wr; dma_addr[i] = addr; dma_wdata[i] = wd;
        end else begin
            cpu_req[i] = req; cpu_wr[i] = wr; cpu_addr[i] = addr; cpu_wdata[i] = wd;
        end
    endtask

    // One complete transaction from an idle arbiter; called just after a clock edge.
    task automatic txn(input int i, input logic dma, input logic wr, input logic [4:0] addr,
                       input logic [15:0] wd, input logic [15:0] rd, input int lat);
        int n;
        n = wr ? 2 : 1 + lat;
        drive(i, dma, 1'b1, wr, addr, wd);
        push(i, dma, rd, cyc + n);
        tick(n);
        drive(i, dma, 1'b0, 1'b0, 5'd0, 16'd0);
        tick(1);
    endtask

    initial begin : stim
        int n;
        Rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(i, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
            drive(i, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0);
        end
        #2 Rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_owner_u%0d", i), owner[i], 0);
            chk($sformatf("rst_cpu_ack_u%0d", i), cpu_ack[i], 0);
            chk($sformatf("rst_dma_ack_u%0d", i), dma_ack[i], 0);
            chk($sformatf("rst_mem_wr_u%0d", i), mem_wr[i], 0);
            chk($sformatf("rst_mem_addr_u%0d", i), mem_addr[i], 0);
            chk($sformatf("rst_mem_wdata_u%0d", i), mem_wdata[i], 0);
            chk($sformatf("rst_rdata_u%0d", i), rdata[i], 0);
        end
        tick(2);
        Rst = 1'b1;

        // CPU write addr 5 = A5A5 on the latency-1 instance, watching the memory strobe.
        n = cyc;
        drive(0, 1'b0, 1'b1, 1'b1, 5'd5, 16'hA5A5);
        push(0, 1'b0, 16'h0000, n + 2);
        tick(1);
        chk("wr_mem_wr_high", mem_wr[0], 1);
        chk("wr_mem_addr", mem_addr[0], 5);
        chk("wr_mem_wdata", mem_wdata[0], 16'hA5A5);
        chk("wr_owner_cpu", owner[0], 1);
        tick(1);
        chk("wr_mem_wr_one_cycle", mem_wr[0], 0);
        chk("wr_addr_held_in_ack", mem_addr[0], 5);
        drive(0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
        tick(1);
        chk("idle_owner_none", owner[0], 0);
        chk("idle_mem_addr_zero", mem_addr[0], 0);
        chk("mem5_written", mem[0][5], 16'hA5A5);

        // Read back through the arbiter.
        txn(0, 1'b0, 1'b0, 5'd5, 16'd0, 16'hA5A5, 1);

        // DMA holds a write request for four back-to-back transactions; rdata must not move.
        n = cyc;
        drive(0, 1'b1, 1'b1, 1'b1, 5'd12, 16'h0C0C);
        for (int k = 0; k < 4; k++) push(0, 1'b1, 16'hA5A5, n + 2 + 3 * k);
        tick(11);
        drive(0, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0);
        tick(1);
        chk("mem12_written", mem[0][12], 16'h0C0C);

        // Latency-3 instance: preload by DMA writes, then reads.
        txn(1, 1'b1, 1'b1, 5'd1, 16'h0101, 16'h0000, 3);
        txn(1, 1'b1, 1'b1, 5'd9, 16'h1234, 16'h0000, 3);
        txn(1, 1'b1, 1'b1, 5'd3, 16'hBEEF, 16'h0000, 3);
        txn(1, 1'b1, 1'b0, 5'd9, 16'd0, 16'h1234, 3);

        // CPU drops its read request in the middle of ACCESS; the read still completes.
        n = cyc;
        drive(1, 1'b0, 1'b1, 1'b0, 5'd3, 16'd0);
        push(1, 1'b0, 16'hBEEF, n + 4);
        tick(2);
        drive(1, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
        chk("drop_owner_held", owner[1], 1);
        chk("drop_rdata_not_yet", rdata[1], 16'h1234);
        tick(3);

        // Reset during a CPU write ACCESS on instance 0.
        drive(0, 1'b0, 1'b1, 1'b1, 5'd7, 16'h7777);
        tick(1);
        chk("pre_rst_mem_wr", mem_wr[0], 1);
        #2 Rst = 1'b0;
        #1;
        chk("rst_mid_mem_wr", mem_wr[0], 0);
        chk("rst_mid_owner", owner[0], 0);
        chk("rst_mid_mem_addr", mem_addr[0], 0);
        chk("rst_mid_cpu_ack", cpu_ack[0], 0);
        // Both instances see both requests high as reset releases.
        drive(0, 1'b0, 1'b1, 1'b1, 5'd8, 16'h8888);
        drive(0, 1'b1, 1'b1, 1'b1, 5'd10, 16'hAAAA);
        drive(1, 1'b0, 1'b1, 1'b0, 5'd1, 16'd0);
        drive(1, 1'b1, 1'b1, 1'b0, 5'd9, 16'd0);
        tick(2);
        Rst = 1'b1;
        n = cyc;
        push(0, 1'b0, 16'h0000, n + 2);
        push(0, 1'b1, 16'h0000, n + 5);
        push(1, 1'b0, 16'h0101, n + 4);
        push(1, 1'b1, 16'h1234, n + 9);
        push(1, 1'b0, 16'h0101, n + 14);
        push(1, 1'b1, 16'h1234, n + 19);
        tick(2);
        drive(0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
        tick(3);
        drive(0, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0);
        tick(9);
        drive(1, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
        tick(5);
        drive(1, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0);
        tick(4);
        chk("aborted_write_absent", {31'd0, mem[0][7] === 16'h7777}, 0);
        chk("mem8_written", mem[0][8], 16'h8888);
        chk("mem10_written", mem[0][10], 16'hAAAA);
        chk("final_owner_u1", owner[1], 0);
        chk("pending_acks_u0", q0.size(), 0);
        chk("pending_acks_u1", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, read latency of data memory in cycles (legal 1..3).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port Rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cpu_req  input  1  CPU control-unit access request, level, held until cpu_ack.
REQ-005 SHALL have port cpu_wr  input  1  CPU access type, 1 = write, 0 = read.
REQ-006 SHALL have port cpu_addr  input  5  CPU word address.
REQ-007 SHALL have port cpu_wdata  input  16  CPU write data.
REQ-008 SHALL have port cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-009 SHALL have port dma_req  input  1  DMA/loader access request, level, held until dma_ack.
REQ-010 SHALL have port dma_wr  input  1  DMA access type, 1 = write.
REQ-011 SHALL have port dma_addr  input  5  DMA word address.
REQ-012 SHALL have port dma_wdata  input  16  DMA write data.
REQ-013 SHALL have port dma_ack  output  1  one-cycle completion pulse to DMA.
REQ-014 SHALL have port rdata  output  16  read data, valid in the cycle the read's ack is high.
REQ-015 SHALL have port mem_addr  output  5  data memory address.
REQ-016 SHALL have port mem_wr  output  1  data memory write strobe.
REQ-017 SHALL have port mem_wdata  output  16  data memory write data.
REQ-018 SHALL have port mem_rdata  input  16  data memory read data, valid MEM_LAT cycles after mem_addr presented.
REQ-019 SHALL have port owner  output  2  current owner: 00 none, 01 CPU, 10 DMA.

Function
REQ-020 SHALL implement states IDLE, ACCESS, ACK; all outputs registered.
REQ-021 IDLE: sample cpu_req/dma_req each edge; any high -> ACCESS next edge; none -> stay IDLE.
REQ-022 Arbitration SHALL be round-robin: single requester wins; both high -> requester not served last wins; last_served updates on entry to ACCESS.
REQ-023 On IDLE->ACCESS edge SHALL latch winner's wr, addr, wdata into internal registers and set owner; requester inputs ignored until return to IDLE.
REQ-024 mem_addr and mem_wdata SHALL drive latched values during ACCESS and ACK; 0 in IDLE.
REQ-025 Write: mem_wr high for exactly the single ACCESS cycle; ACCESS lasts 1 cycle regardless of MEM_LAT.
REQ-026 Read: mem_wr stays 0; ACCESS lasts MEM_LAT cycles via 2-bit down-counter; mem_rdata captured into rdata on final ACCESS edge.
REQ-027 ACK: owner's ack high exactly one cycle; other ack stays 0; next edge -> IDLE, owner = 00.
REQ-028 Latency: req high at edge N -> ack high after edge N+2 (write) or N+1+MEM_LAT (read).
REQ-029 rdata SHALL hold last read value until next read completes; writes do not alter rdata.
REQ-030 Requester dropping req mid-transaction SHALL NOT abort; transaction completes and ack still pulses.
REQ-031 req still high in IDLE after ack SHALL be treated as a new request, subject to round-robin.
REQ-032 Back-to-back: both requesters continuously high -> grants strictly alternate, one transaction per (2+latency) cycles, no IDLE bubble beyond one cycle.

Reset
REQ-033 Rst low SHALL immediately force IDLE, owner=00, cpu_ack=dma_ack=0, mem_wr=0, mem_addr=0, mem_wdata=0, rdata=0, counter=0, last_served=DMA (CPU wins first tie).
REQ-034 Rst mid-ACCESS SHALL abandon transaction with no ack; mem_wr drops asynchronously.

Verification
REQ-035 CPU write addr 5 data 16'hA5A5, MEM_LAT=1 -> mem_wr high one cycle with mem_addr=5, cpu_ack at N+2, dma_ack 0.
REQ-036 DMA read addr 9, memory holds 16'h1234, MEM_LAT=3 -> dma_ack at N+4, rdata=16'h1234 that cycle.
REQ-037 Both req high from reset, continuous -> order CPU, DMA, CPU, DMA; owner toggles 01/10.
REQ-038 CPU drops req during read ACCESS -> cpu_ack still pulses, rdata updated.
REQ-039 Rst asserted during write ACCESS -> mem_wr 0 same cycle, no ack, owner 00; after release CPU wins tie.
REQ-040 Single requester held high 4 transactions -> 4 acks, one IDLE cycle between each, other ack never high.
